// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the unified MIPS instruction/data memory arbiter.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_RESP    = 2'd2
    } mem_state_t;

    localparam logic [1:0] MW_NONE  = 2'b00;
    localparam logic [1:0] MW_WORD  = 2'b01;
    localparam logic [1:0] MW_DWORD = 2'b10;

    // size is MW_WORD or MW_DWORD; addr carries the low three byte-address bits
    function automatic logic is_aligned(input logic [2:0] addr, input logic [1:0] size);
        if (size == MW_DWORD) begin
            return addr == 3'b000;
        end
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 32 word store: one synchronous 1-or-2-word write port, async access and debug reads.
module mem_word_array #(
    parameter int DEPTH = 256,
    parameter int CHKW  = 8,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic            we2,
    input  logic [IW-1:0]   waddr,
    input  logic [31:0]     wdata0,
    input  logic [31:0]     wdata1,
    input  logic [IW-1:0]   raddr,
    output logic [31:0]     rdata0,
    output logic [31:0]     rdata1,
    input  logic [CHKW-1:0] dbg_addr,
    output logic [31:0]     dbg_rdata
);

    logic [31:0]   mem [DEPTH];
    logic [IW-1:0] waddr1;
    logic [IW-1:0] raddr1;
    logic [IW-1:0] dbg_idx;

    assign waddr1  = waddr + IW'(1);
    assign raddr1  = raddr + IW'(1);
    assign dbg_idx = IW'(dbg_addr);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata0;
            if (we2) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    assign rdata0 = mem[raddr];
    assign rdata1 = mem[raddr1];

    // Debug addresses beyond the array read as zero rather than aliasing.
    assign dbg_rdata = (32'(dbg_addr) < DEPTH) ? mem[dbg_idx] : 32'd0;

endmodule

// File: rtl/mips_mem_arb.sv
// Round-robin arbiter and wait-state FSM sharing one word array between fetch and data channels.
module mips_mem_arb
    import mips_mem_pkg::*;
#(
    parameter int N     = 64,
    parameter int AW    = 32,
    parameter int DEPTH = 256,
    parameter int WAIT  = 1,
    parameter int CHKW  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ready,
    output logic [31:0]     i_rdata,
    output logic            i_err,
    input  logic            d_req,
    input  logic [AW-1:0]   d_addr,
    input  logic [1:0]      d_we,
    input  logic            d_rtype,
    input  logic [N-1:0]    d_wdata,
    output logic            d_ready,
    output logic [N-1:0]    d_rdata,
    output logic            d_err,
    input  logic [CHKW-1:0] checkma,
    output logic [31:0]     checkm
);

    localparam int IW  = $clog2(DEPTH);
    localparam int IXW = AW - 2;

    mem_state_t    state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          ptr_reg, ptr_next;      // 1: data channel wins the next contested grant
    logic          gnt_d_reg, gnt_d_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [1:0]    we_reg, we_next;
    logic          rtype_reg, rtype_next;
    logic [N-1:0]  wdata_reg, wdata_next;
    logic          i_ready_reg, i_ready_next, i_err_reg, i_err_next;
    logic          d_ready_reg, d_ready_next, d_err_reg, d_err_next;
    logic [31:0]   i_rdata_reg, i_rdata_next;
    logic [N-1:0]  d_rdata_reg, d_rdata_next;

    logic           in_idle, pick_d, sel_d, sel_rtype, sel_dw, in_range, sel_err;
    logic [1:0]     d_we_norm, sel_we;
    logic [AW-1:0]  sel_addr;
    logic [IXW-1:0] sel_idx;
    logic [31:0]    rdata0, rdata1;
    logic [63:0]    d_rd64, wdata_ext;
    logic           wr_en, enter_resp;

    // In IDLE the live request is decoded so a zero-wait access can respond immediately.
    assign in_idle   = (state_reg == ST_IDLE);
    assign pick_d    = d_req && (!i_req || ptr_reg);
    assign d_we_norm = (d_we == MW_WORD || d_we == MW_DWORD) ? d_we : MW_NONE;
    assign sel_d     = in_idle ? pick_d : gnt_d_reg;
    assign sel_addr  = in_idle ? (pick_d ? d_addr : i_addr) : addr_reg;
    assign sel_we    = in_idle ? (pick_d ? d_we_norm : MW_NONE) : we_reg;
    assign sel_rtype = in_idle ? d_rtype : rtype_reg;
    assign sel_idx   = sel_addr[AW-1:2];

    assign sel_dw   = (sel_we == MW_DWORD) || (sel_d && sel_we == MW_NONE && !sel_rtype && N == 64);
    assign in_range = sel_dw ? (sel_idx < IXW'(DEPTH - 1)) : (sel_idx < IXW'(DEPTH));
    assign sel_err  = !is_aligned(sel_addr[2:0], sel_dw ? MW_DWORD : MW_WORD) || !in_range
                      || (sel_we == MW_DWORD && N == 32);

    assign d_rd64 = sel_rtype ? {{32{rdata0[31]}}, rdata0}
                  : (N == 64) ? {rdata1, rdata0} : {32'd0, rdata0};

    assign wdata_ext = 64'(wdata_reg);
    assign wr_en     = (state_reg == ST_RESP) && !sel_err && (we_reg != MW_NONE);

    mem_word_array #(
        .DEPTH (DEPTH),
        .CHKW  (CHKW),
        .IW    (IW)
    ) u_array (
        .clk       (clk),
        .we        (wr_en),
        .we2       (we_reg == MW_DWORD),
        .waddr     (IW'(addr_reg[AW-1:2])),
        .wdata0    (wdata_ext[31:0]),
        .wdata1    (wdata_ext[63:32]),
        .raddr     (IW'(sel_idx)),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .dbg_addr  (checkma),
        .dbg_rdata (checkm)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        gnt_d_next = gnt_d_reg;
        addr_next  = addr_reg;
        we_next    = we_reg;
        rtype_next = rtype_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    gnt_d_next = pick_d;
                    addr_next  = sel_addr;
                    we_next    = sel_we;
                    rtype_next = d_rtype;
                    wdata_next = d_wdata;
                    if (i_req && d_req) begin
                        ptr_next = !ptr_reg;
                    end
                    if (WAIT > 0) begin
                        state_next = ST_WAITING;
                        cnt_next   = 4'(WAIT - 1);
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_WAITING: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        enter_resp   = (state_next == ST_RESP);
        i_ready_next = enter_resp && !sel_d;
        d_ready_next = enter_resp && sel_d;
        i_err_next   = enter_resp && !sel_d && sel_err;
        d_err_next   = enter_resp && sel_d && sel_err;
        i_rdata_next = (enter_resp && !sel_d && !sel_err) ? rdata0 : 32'd0;
        d_rdata_next = (enter_resp && sel_d && !sel_err && sel_we == MW_NONE) ? N'(d_rd64) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 4'd0;
            ptr_reg     <= 1'b1;
            gnt_d_reg   <= 1'b0;
            addr_reg    <= '0;
            we_reg      <= MW_NONE;
            rtype_reg   <= 1'b0;
            wdata_reg   <= '0;
            i_ready_reg <= 1'b0;
            i_err_reg   <= 1'b0;
            i_rdata_reg <= 32'd0;
            d_ready_reg <= 1'b0;
            d_err_reg   <= 1'b0;
            d_rdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ptr_reg     <= ptr_next;
            gnt_d_reg   <= gnt_d_next;
            addr_reg    <= addr_next;
            we_reg      <= we_next;
            rtype_reg   <= rtype_next;
            wdata_reg   <= wdata_next;
            i_ready_reg <= i_ready_next;
            i_err_reg   <= i_err_next;
            i_rdata_reg <= i_rdata_next;
            d_ready_reg <= d_ready_next;
            d_err_reg   <= d_err_next;
            d_rdata_reg <= d_rdata_next;
        end
    end

    assign i_ready = i_ready_reg;
    assign i_err   = i_err_reg;
    assign i_rdata = i_rdata_reg;
    assign d_ready = d_ready_reg;
    assign d_err   = d_err_reg;
    assign d_rdata = d_rdata_reg;

endmodule

// File: doc/mips_mem_arb.md
Name: mips_mem_arb

Overview:
- Parametrised unified-memory successor to the single-cycle instruction/data memory pairing in the MIPS top level.
- One single-ported word array serves two request channels, instruction fetch and data load/store, through a req/ready handshake.
- Features: configurable wait states, round-robin arbitration, alignment/range error reporting, and a combinational debug read port.
- Sits between the `mips` core and backing storage.

Parameters:
- N, 64, data-channel width (64 or 32).
- AW, 32, address width, byte addresses.
- DEPTH, 256, memory depth in 32-bit words; power of two.
- WAIT, 1, extra wait cycles per access (0..15).
- CHKW, 8, debug word-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_req  in  1  instruction fetch request; held until i_ready.
- i_addr  in  AW  fetch byte address.
- i_ready  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  32  fetched word.
- i_err  out  1  qualified by i_ready; misaligned or out of range.
- d_req  in  1  data request; held with all d_* inputs until d_ready.
- d_addr  in  AW  data byte address.
- d_we  in  2  00 read, 01 write word, 10 write doubleword, 11 treated as read.
- d_rtype  in  1  read type: 0 = N-bit read; 1 = 32-bit read, sign-extended to N.
- d_wdata  in  N  store data.
- d_ready  out  1  one-cycle pulse completing the data access.
- d_rdata  out  N  load data, valid with d_ready.
- d_err  out  1  qualified by d_ready.
- checkma  in  CHKW  debug word address.
- checkm  out  32  combinational read of mem[checkma]; 0 if checkma >= DEPTH.

Behaviour:
- Reset (reset==0, async):
  - State IDLE; i_ready, d_ready, i_err, d_err = 0; i_rdata, d_rdata = 0; wait counter = 0; priority pointer = data.
  - Memory contents are not cleared.
- FSM states: IDLE, WAITING, RESP.
- IDLE:
  - If any req, grant one channel and latch the address, we, rtype and wdata into internal registers.
  - Next state is WAITING if WAIT>0 (counter loaded with WAIT-1), else RESP.
- WAITING: decrement the counter; at 0, go to RESP.
- RESP:
  - Perform the access: array read, or write at the clock edge.
  - Assert the granted channel's ready and err for exactly this cycle; rdata registered with ready.
  - Return to IDLE.
  - The next grant cannot occur in the same cycle, so back-to-back accesses are spaced WAIT+2 cycles.
- Latency: req sampled high in IDLE at edge t; ready high during cycle t+WAIT+1 (WAIT=1 → 3 cycles req-to-ready inclusive).
- Arbitration:
  - Only one channel requesting: grant it.
  - Both requesting: grant the channel named by the priority pointer, then flip the pointer to the other channel.
  - The pointer flips only on a contested grant.
- Alignment:
  - Instruction and word access need addr[1:0]==0.
  - Doubleword access needs addr[2:0]==0 and N==64; if N==32 a doubleword write is an error.
  - Misaligned access: err=1, no write, rdata=0.
- Range:
  - Word index = addr[AW-1:2]. A word access or fetch is valid if index < DEPTH; a doubleword needs index+1 < DEPTH.
  - Out of range: err=1, no write, rdata=0.
- Doubleword layout: little-endian, lower word at index, upper word at index+1.
- Doubleword reads:
  - d_rtype=0 with N==64: {mem[idx+1], mem[idx]}.
  - d_rtype=1: sign-extended mem[idx].
- Word write: stores d_wdata[31:0] only.
- Debug port: reflects the array combinationally; a write in RESP is visible on checkm the cycle after the edge.
- Protocol violation: if a requester drops req before ready, the access still completes using the latched values and ready still pulses.
- Reset mid-access: the access is abandoned, no write occurs, no ready pulse, and the FSM returns to IDLE.

Decomposition:
- Package `mips_mem_pkg`:
  - enum for the memory FSM state.
  - constants MW_NONE=2'b00, MW_WORD=2'b01, MW_DWORD=2'b10.
  - function `is_aligned(addr, size)`.
- One sub-module `mem_word_array`: DEPTH×32 array with one synchronous write port of 1 or 2 consecutive words and two async read ports (access port and debug port).
- The arbiter/FSM lives in `mips_mem_arb`.

Test Plan:
- WAIT=1, d_req write doubleword 0x1122334455667788 at 0x10 → d_ready after 3 cycles, d_err=0; checkm at checkma=4 shows 0x55667788, at checkma=5 shows 0x11223344.
- Read back 0x10 with d_rtype=1 → d_rdata=0x0000000055667788. Store word 0x80000000 at 0x18, then read with d_rtype=1 → 0xFFFFFFFF80000000.
- i_req and d_req both asserted continuously from reset → grants alternate D, I, D, I, each ready spaced 3 cycles apart, with no starvation over 20 accesses.
- d_we=10 at 0x14 (misaligned) → d_err=1 with d_ready; checkm at words 5 and 6 unchanged. i_addr=0x400 with DEPTH=256 → i_err=1, i_rdata=0.
- WAIT=0 → ready one cycle after grant. WAIT=4 → ready on the 6th cycle.
- Assert reset=0 during WAITING of a write → no d_ready, memory unchanged, all outputs 0; after release, a new request completes normally.
